// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state type, bit-count constants and parity helper for the UART transmitter
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int DATA_BITS = 8;
    localparam int BIT_IDX_W = $clog2(DATA_BITS);

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO, power-of-2 depth
// Storage is deliberately left out of reset; only pointers and occupancy are cleared.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       s_tdata,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    output logic [WIDTH-1:0]       m_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push;
    logic             pop;

    assign s_tready = (level_q != LW'(DEPTH));
    assign m_tvalid = (level_q != '0);
    assign m_tdata  = mem[rd_ptr_q];
    assign level    = level_q;
    assign push     = s_tvalid && s_tready;
    assign pop      = m_tready && m_tvalid;

    // Pointers wrap by natural overflow because DEPTH is a power of 2.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= s_tdata;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered 8N1 UART transmitter; define UART_TX_PARITY_EN for 8E1 framing
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        fpga_sysclk,
    input  logic                        rst_fpga_,
    input  logic [7:0]                  in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        uart_txd,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] level
);
    localparam int                   DIV      = CLK_HZ / BAUD;
    localparam int                   CW       = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]        DIV_M1   = CW'(DIV - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_fifo: CLK_HZ/BAUD must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, at least 2");
    end

    tx_state_t              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    logic [DATA_BITS-1:0]   fifo_tdata;
    logic                   fifo_tvalid;
    logic                   fifo_pop;
    logic                   bit_done;
    logic                   start_frame;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (fpga_sysclk),
        .rst_n    (rst_fpga_),
        .s_tdata  (in_data),
        .s_tvalid (in_valid),
        .s_tready (in_ready),
        .m_tdata  (fifo_tdata),
        .m_tvalid (fifo_tvalid),
        .m_tready (fifo_pop),
        .level    (level)
    );

    assign bit_done = (cnt_q == '0);
    assign uart_txd = txd_q;
    assign busy     = (state_q != IDLE) || (level != '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        txd_d       = txd_q;
        fifo_pop    = 1'b0;
        start_frame = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d    = parity_q;
`endif
        case (state_q)
            IDLE: begin
                start_frame = fifo_tvalid;
            end
            START: begin
                if (!bit_done) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d   = DATA;
                    cnt_d     = DIV_M1;
                    bit_idx_d = '0;
                    txd_d     = shift_q[0];
                end
            end
            DATA: begin
                if (!bit_done) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    cnt_d = DIV_M1;
                    if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        txd_d   = parity_q;
`else
                        state_d = STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                        shift_d   = shift_q >> 1;
                        txd_d     = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (!bit_done) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = STOP;
                    cnt_d   = DIV_M1;
                    txd_d   = 1'b1;
                end
            end
`endif
            STOP: begin
                if (!bit_done) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (fifo_tvalid) begin
                    start_frame = 1'b1;
                end else begin
                    state_d = IDLE;
                    txd_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase

        // Popping on the same edge that drives the start bit gives back-to-back frames with no gap.
        if (start_frame) begin
            fifo_pop = 1'b1;
            state_d  = START;
            cnt_d    = DIV_M1;
            shift_d  = fifo_tdata;
            txd_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d = even_parity(fifo_tdata);
`endif
        end
    end

    always_ff @(posedge fpga_sysclk or negedge rst_fpga_) begin
        if (!rst_fpga_) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule
